// File: rtl/mul_stage_if.sv
// ---------------------------------------------------------------------------
// mul_stage_if
//
// Purpose : Groups the operand-side and product-side handshakes of
//           mul_stage into one bundle.
//
// Signals : in_valid   operand pair present
//           in_ready   stage can accept an operand pair this cycle
//           op         2-bit operation select
//                        00 = u x u, 01 = s x s, 10 = s(a) x u(b), 11 = u x u
//           a          operand a, XLEN bits
//           b          operand b, YLEN bits
//           out_valid  product valid
//           out_ready  consumer accepts the product
//           c          product, XLEN+YLEN bits
//
// Modports: master  issue/writeback side, which drives operands and accepts products
//           slave   the multiplier stage itself
// ---------------------------------------------------------------------------
interface mul_stage_if #(
    parameter int XLEN = 32,
    parameter int YLEN = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [1:0]             op;
    logic [XLEN-1:0]        a;
    logic [YLEN-1:0]        b;
    logic                   out_valid;
    logic                   out_ready;
    logic [XLEN+YLEN-1:0]   c;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, c
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, c
    );
endinterface

// File: rtl/mul_stage.sv
// ---------------------------------------------------------------------------
// mul / mul_stage
//
// Purpose : Two-register pipelined multiplier with valid/ready handshakes on
//           both sides. Stage 1 registers the operand magnitudes and the
//           result sign. An unsigned combinational tree (mul) forms the
//           magnitude product. Stage 2 registers the product with the sign
//           applied. Throughput is one product per cycle, and backpressure
//           is full.
//
// Ports   : clock   rising-edge clock
//           reset   asynchronous, active-low reset
//           bus     mul_stage_if.slave. Carries in_valid/in_ready/op/a/b on
//                   the operand side and out_valid/out_ready/c on the
//                   product side.
//
// Params  : XLEN, YLEN  operand widths (they may differ)
//           TYP         tree type: 0 = Dadda, 1 = Wallace-style carry-save
// ---------------------------------------------------------------------------

// Unsigned combinational multiplier. The product width is XLEN+YLEN, so no
// truncation occurs.
module mul #(
    parameter int XLEN = 32,
    parameter int YLEN = 32,
    parameter int TYP  = 0
) (
    input  logic [XLEN-1:0]      x,
    input  logic [YLEN-1:0]      y,
    output logic [XLEN+YLEN-1:0] p
);
    localparam int W = XLEN + YLEN;

    if (TYP == 1) begin : g_csa
        // Each partial-product row is folded into a (sum, carry) pair by a
        // row of 3:2 compressors. One carry-propagate add closes the tree.
        // Carries shifted past bit W-1 are dropped safely, because the true
        // product always fits in W bits.
        logic [W-1:0] sum;
        logic [W-1:0] carry;
        logic [W-1:0] pp;
        logic [W-1:0] t;

        // NOTE: every variable written here gets a value before any path
        // reads it, so no latch can be inferred.
        always_comb begin
            sum   = '0;
            carry = '0;
            pp    = '0;
            t     = '0;
            for (int i = 0; i < YLEN; i++) begin
                pp    = y[i] ? (W'(x) << i) : '0;
                t     = sum ^ carry ^ pp;
                carry = ((sum & carry) | (sum & pp) | (carry & pp)) << 1;
                sum   = t;
            end
            p = sum + carry;
        end
    end else begin : g_dadda
        // The Dadda reduction is left to the synthesis multiplier mapping.
        assign p = W'(x) * W'(y);
    end
endmodule

module mul_stage #(
    parameter int XLEN = 32,
    parameter int YLEN = 32,
    parameter int TYP  = 0
) (
    input  logic       clock,
    input  logic       reset,
    mul_stage_if.slave bus
);
    localparam int W = XLEN + YLEN;

    logic            s1_valid;
    logic            s1_neg;
    logic [XLEN-1:0] s1_ma;
    logic [YLEN-1:0] s1_mb;

    logic            s2_valid;
    logic [W-1:0]    s2_c;

    logic [W-1:0]    prod;
    logic            sa;
    logic            sb;
    logic            s2_free;
    logic            s1_adv;
    logic            accept;

    // Operand signs. Op 11 is reserved and behaves like 00.
    assign sa = ((bus.op == 2'b01) || (bus.op == 2'b10)) && bus.a[XLEN-1];
    assign sb = (bus.op == 2'b01) && bus.b[YLEN-1];

    // in_ready depends only on state and out_ready, never on in_valid.
    assign s2_free      = !s2_valid || bus.out_ready;
    assign s1_adv       = s1_valid && s2_free;
    assign bus.in_ready = !s1_valid || s1_adv;
    assign accept       = bus.in_valid && bus.in_ready;

    // The tree sees only the registered magnitudes, never the ports.
    mul #(
        .XLEN (XLEN),
        .YLEN (YLEN),
        .TYP  (TYP)
    ) u_mul (
        .x (s1_ma),
        .y (s1_mb),
        .p (prod)
    );

    // Stage 1 holds the magnitudes and the result sign. Negating the most
    // negative value gives 2^(N-1), which still fits as an unsigned value.
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples values from before the edge. The data registers are plain
    // flops here, not a memory, so they can be reset cheaply.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_neg   <= 1'b0;
            s1_ma    <= '0;
            s1_mb    <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_neg   <= sa ^ sb;
            s1_ma    <= sa ? -bus.a : bus.a;
            s1_mb    <= sb ? -bus.b : bus.b;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2 applies the sign. Negating a zero product gives zero again.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s2_valid <= 1'b0;
            s2_c     <= '0;
        end else if (s1_adv) begin
            s2_valid <= 1'b1;
            s2_c     <= s1_neg ? -prod : prod;
        end else if (bus.out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.c         = s2_c;
endmodule

// File: tb/tb_mul_stage.sv
// ---------------------------------------------------------------------------
// tb_mul_stage
//
// Drives one stimulus stream into two mul_stage instances, one per tree type,
// at XLEN = YLEN = 8. The reference model is a queue of expected products.
// The products are computed with plain integer arithmetic and stamped with
// their accept edge. Directed vectors pin literal values.
// ---------------------------------------------------------------------------
module tb_mul_stage;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;

    always #5 clk = ~clk;

    mul_stage_if #(.XLEN(8), .YLEN(8)) if0 ();
    mul_stage_if #(.XLEN(8), .YLEN(8)) if1 ();

    assign if0.in_valid  = in_valid;
    assign if0.out_ready = out_ready;
    assign if0.op        = op;
    assign if0.a         = a;
    assign if0.b         = b;
    assign if1.in_valid  = in_valid;
    assign if1.out_ready = out_ready;
    assign if1.op        = op;
    assign if1.a         = a;
    assign if1.b         = b;

    mul_stage #(.XLEN(8), .YLEN(8), .TYP(0)) dut0 (.clock(clk), .reset(rst_n), .bus(if0));
    mul_stage #(.XLEN(8), .YLEN(8), .TYP(1)) dut1 (.clock(clk), .reset(rst_n), .bus(if1));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference product: operands are interpreted as integers, and the
    // result is taken modulo 2^16.
    function automatic logic [15:0] ref_prod(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        int xi;
        int yi;
        int p;
        xi = int'(x);
        yi = int'(y);
        if (o == 2'b01 || o == 2'b10) xi = int'($signed(x));
        if (o == 2'b01)               yi = int'($signed(y));
        p = xi * yi;
        return p[15:0];
    endfunction

    // Model: an item accepted at edge N becomes visible after edge N+1,
    // once it reaches the head of the queue.
    typedef struct {
        int          acc;
        logic [15:0] prod;
    } item_t;

    item_t q[$];
    int    edge_cnt = 0;
    int    n_in  = 0;
    int    n_out = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(negedge clk) begin
        logic exp_valid;
        logic exp_ready;
        if (!rst_n) begin
            q.delete();
        end else begin
            exp_valid = (q.size() > 0) && (q[0].acc + 1 <= edge_cnt);
            exp_ready = (q.size() < 2) || out_ready;
            check("m_out_valid0", 32'(if0.out_valid), 32'(exp_valid));
            check("m_out_valid1", 32'(if1.out_valid), 32'(exp_valid));
            check("m_in_ready0",  32'(if0.in_ready),  32'(exp_ready));
            check("m_in_ready1",  32'(if1.in_ready),  32'(exp_ready));
            if (exp_valid) begin
                check("m_c0", 32'(if0.c), 32'(q[0].prod));
                check("m_c1", 32'(if1.c), 32'(q[0].prod));
                if (out_ready) begin
                    void'(q.pop_front());
                    n_out++;
                end
            end
            if (in_valid && exp_ready) begin
                q.push_back('{acc: edge_cnt + 1, prod: ref_prod(op, a, b)});
                n_in++;
            end
        end
    end

    // Present one pair and hold it until it is accepted (bounded).
    task automatic send(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        int n = 0;
        in_valid = 1'b1;
        op = o;
        a  = x;
        b  = y;
        @(negedge clk);
        while (!if0.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_accept", 32'(if0.in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Send one pair with the consumer open. The product must be valid
    // after the second edge.
    task automatic one_shot(input string name, input logic [1:0] o, input logic [7:0] x,
                            input logic [7:0] y, input logic [15:0] exp);
        out_ready = 1'b1;
        send(o, x, y);
        @(posedge clk);
        #1;
        check({name, "_valid0"}, 32'(if0.out_valid), 32'd1);
        check({name, "_valid1"}, 32'(if1.out_valid), 32'd1);
        check({name, "_c0"}, 32'(if0.c), 32'(exp));
        check({name, "_c1"}, 32'(if1.c), 32'(exp));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] bp_exp [4];
        int base_in;
        int base_out;
        int cyc;
        bp_exp = '{16'h0001, 16'h0004, 16'h0009, 16'h0010};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op = '0;
        a  = '0;
        b  = '0;
        #2;
        check("rst_out_valid", 32'(if0.out_valid), 32'd0);
        check("rst_c",         32'(if0.c),         32'd0);
        check("rst_in_ready",  32'(if0.in_ready),  32'd1);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors
        one_shot("uu_ff_ff",  2'b00, 8'hFF, 8'hFF, 16'hFE01);
        one_shot("ss_80_ff",  2'b01, 8'h80, 8'hFF, 16'h0080);
        one_shot("ss_80_7f",  2'b01, 8'h80, 8'h7F, 16'hC080);
        one_shot("su_ff_ff",  2'b10, 8'hFF, 8'hFF, 16'hFF01);
        one_shot("rsv_02_03", 2'b11, 8'h02, 8'h03, 16'h0006);
        one_shot("ss_zero",   2'b01, 8'h00, 8'h85, 16'h0000);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: two products in flight, then release.
        out_ready = 1'b0;
        fork
            begin
                send(2'b00, 8'd1, 8'd1);
                send(2'b00, 8'd2, 8'd2);
                send(2'b00, 8'd3, 8'd3);
                send(2'b00, 8'd4, 8'd4);
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                check("bp_in_ready_low", 32'(if0.in_ready),  32'd0);
                check("bp_valid_hold",   32'(if0.out_valid), 32'd1);
                check("bp_c_hold0",      32'(if0.c),         32'h0001);
                check("bp_c_hold1",      32'(if1.c),         32'h0001);
                out_ready = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    check("bp_flow_valid", 32'(if0.out_valid), 32'd1);
                    check("bp_flow_c0",    32'(if0.c),         32'(bp_exp[k]));
                    check("bp_flow_c1",    32'(if1.c),         32'(bp_exp[k]));
                    @(posedge clk);
                    #1;
                end
            end
        join
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-flight
        out_ready = 1'b0;
        send(2'b00, 8'd5, 8'd7);
        send(2'b00, 8'd9, 8'd9);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mr_out_valid0", 32'(if0.out_valid), 32'd0);
        check("mr_out_valid1", 32'(if1.out_valid), 32'd0);
        check("mr_c0",         32'(if0.c),         32'd0);
        check("mr_c1",         32'(if1.c),         32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        one_shot("mr_ss_fe_03", 2'b01, 8'hFE, 8'h03, 16'hFFFA);
        repeat (2) @(posedge clk);
        #1;

        // Random traffic
        base_in  = n_in;
        base_out = n_out;
        cyc = 0;
        while ((n_in - base_in) < 10000 && cyc < 60000) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            op = 2'($urandom_range(3));
            a  = 8'($urandom);
            b  = 8'($urandom);
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (q.size() != 0 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("rnd_drained",    32'(q.size()),         32'd0);
        check("rnd_count_io",   32'(n_out - base_out), 32'(n_in - base_in));
        check("rnd_enough_in",  32'((n_in - base_in) >= 10000), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
